// File: rtl/led_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// led_pattern_sequencer
//
// Purpose:
//   Takes the slow square wave produced by the clock divider (same clock
//   domain), turns its edges into single-cycle step strobes and advances one
//   of four LED patterns on each strobe. A one-cycle wrap pulse marks the end
//   of every pattern period for downstream status logic.
//
// Ports:
//   clock_in  in   system clock (same clock as the divider)
//   reset     in   synchronous, active-high reset
//   tick_in   in   slow square wave from the divider
//   run       in   1 = running, 0 = stopped with LEDs dark
//   hold      in   1 = freeze the pattern while running (steps discarded)
//   mode      in   [1:0] 0 walk, 1 binary, 2 bounce, 3 blink
//   dir       in   0 = up/left, 1 = down/right (walk and binary only)
//   leds      out  [LED_COUNT-1:0] LED drive, active-high
//   wrap      out  one-cycle pulse when the pattern completes a period
//
// Parameters:
//   LED_COUNT  number of LEDs, 2..16
//
// Build option:
//   LED_SEQ_BOTH_EDGES_EN  when defined, both edges of tick_in produce a
//                          step (one step per divider interval); otherwise
//                          only rising edges step the pattern.
// ---------------------------------------------------------------------------
module led_pattern_sequencer #(
  parameter int LED_COUNT = 5
) (
  input  logic                 clock_in,
  input  logic                 reset,
  input  logic                 tick_in,
  input  logic                 run,
  input  logic                 hold,
  input  logic [1:0]           mode,
  input  logic                 dir,
  output logic [LED_COUNT-1:0] leds,
  output logic                 wrap
);

  localparam int IDX_W = $clog2(LED_COUNT);
  localparam logic [IDX_W-1:0]     IDX_LAST     = IDX_W'(LED_COUNT - 1);
  localparam logic [LED_COUNT-1:0] LED_NONE     = '0;
  localparam logic [LED_COUNT-1:0] LED_ALL      = '1;
  localparam logic [LED_COUNT-1:0] LED_LSB      = LED_COUNT'(1);
  localparam logic [LED_COUNT-1:0] LED_MSB      = LED_LSB << (LED_COUNT - 1);
  // One position short of either end of the bounce travel; the direction
  // flag flips on the step that leaves these positions.
  localparam logic [LED_COUNT-1:0] LED_NEAR_MSB = LED_MSB >> 1;
  localparam logic [LED_COUNT-1:0] LED_NEAR_LSB = LED_LSB << 1;

  typedef enum logic [0:0] {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_t;

  state_t               state_reg, state_next;
  logic [LED_COUNT-1:0] leds_reg, leds_next;
  logic                 wrap_reg, wrap_next;
  logic [IDX_W-1:0]     index_reg, index_next;
  logic                 bounce_dn_reg, bounce_dn_next;
  logic                 tick_q;
  logic [1:0]           mode_q;

  logic                 step;
  logic [LED_COUNT-1:0] start_pattern;
  logic [LED_COUNT-1:0] rot_left;
  logic [LED_COUNT-1:0] rot_right;

`ifdef LED_SEQ_BOTH_EDGES_EN
  assign step = tick_in ^ tick_q;
`else
  assign step = tick_in & ~tick_q;
`endif

  // Single-position rotations of the current pattern, used by walk mode.
  genvar gi;
  generate
    for (gi = 0; gi < LED_COUNT; gi++) begin : g_rot
      assign rot_left[gi]  = leds_reg[(gi + LED_COUNT - 1) % LED_COUNT];
      assign rot_right[gi] = leds_reg[(gi + 1) % LED_COUNT];
    end
  endgenerate

  always_comb begin
    case (mode)
      2'd0, 2'd2: start_pattern = LED_LSB;
      default:    start_pattern = LED_NONE;
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    leds_next      = leds_reg;
    wrap_next      = 1'b0;
    index_next     = index_reg;
    bounce_dn_next = bounce_dn_reg;

    case (state_reg)
      STOPPED: begin
        leds_next = LED_NONE;
        if (run) begin
          // Starting always loads a fresh pattern; a coincident step is lost.
          state_next     = RUNNING;
          leds_next      = start_pattern;
          index_next     = '0;
          bounce_dn_next = 1'b0;
        end
      end

      RUNNING: begin
        if (!run) begin
          state_next = STOPPED;
          leds_next  = LED_NONE;
        end else if (mode != mode_q) begin
          // Mode switch restarts the new pattern; it never counts as a wrap.
          leds_next      = start_pattern;
          index_next     = '0;
          bounce_dn_next = 1'b0;
        end else if (step && !hold) begin
          case (mode)
            2'd0: begin
              // index tracks steps taken, independent of direction, so a
              // mid-period dir change does not move the wrap point.
              leds_next = dir ? rot_right : rot_left;
              if (index_reg == IDX_LAST) begin
                index_next = '0;
                wrap_next  = 1'b1;
              end else begin
                index_next = index_reg + IDX_W'(1);
              end
            end
            2'd1: begin
              if (dir) begin
                leds_next = leds_reg - LED_LSB;
                wrap_next = (leds_reg == LED_NONE);
              end else begin
                leds_next = leds_reg + LED_LSB;
                wrap_next = (leds_reg == LED_ALL);
              end
            end
            2'd2: begin
              if (!bounce_dn_reg) begin
                leds_next = leds_reg << 1;
                if (leds_reg == LED_NEAR_MSB) begin
                  bounce_dn_next = 1'b1;
                end
              end else begin
                leds_next = leds_reg >> 1;
                if (leds_reg == LED_NEAR_LSB) begin
                  bounce_dn_next = 1'b0;
                  wrap_next      = 1'b1;
                end
              end
            end
            2'd3: begin
              leds_next = (leds_reg == LED_NONE) ? LED_ALL : LED_NONE;
              wrap_next = (leds_reg != LED_NONE);
            end
          endcase
        end
      end

      default: begin
        state_next = STOPPED;
        leds_next  = LED_NONE;
      end
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_reg     <= STOPPED;
      leds_reg      <= '0;
      wrap_reg      <= 1'b0;
      index_reg     <= '0;
      bounce_dn_reg <= 1'b0;
      tick_q        <= 1'b0;
      mode_q        <= 2'd0;
    end else begin
      state_reg     <= state_next;
      leds_reg      <= leds_next;
      wrap_reg      <= wrap_next;
      index_reg     <= index_next;
      bounce_dn_reg <= bounce_dn_next;
      tick_q        <= tick_in;
      mode_q        <= mode;
    end
  end

  assign leds = leds_reg;
  assign wrap = wrap_reg;

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
- Consumes the divided slow square wave (`clock_out` of the clock divider) as a same-domain data input `tick_in`.
- Edge-detects it to form single-cycle step strobes, then advances a selectable LED pattern on each strobe.
- Sits between the clock divider and the board LED pins.
- Provides run/hold control, direction control and a pattern-wrap pulse for downstream status logic.

Parameters:
- LED_COUNT, 5, number of LED outputs; legal range 2..16.

Ports:
- clock_in  input  1  system clock; same clock as the divider.
- reset  input  1  synchronous, active-high; sampled on rising clock_in.
- tick_in  input  1  slow square wave from the divider; registered in the clock_in domain.
- run  input  1  1 = sequencer running, 0 = stopped with LEDs dark.
- hold  input  1  1 = freeze the current pattern while running; steps are discarded.
- mode  input  2  pattern select: 0 walk, 1 binary, 2 bounce, 3 blink.
- dir  input  1  0 = up/left, 1 = down/right; used by modes 0 and 1 only.
- leds  output  LED_COUNT  LED drive, active-high.
- wrap  output  1  one-cycle pulse when the pattern completes a period.

Behaviour:
Interface:
- One clock, clock_in; reset is synchronous and active-high. There is no asynchronous reset path.

Reset:
- On reset: leds=0, wrap=0, state=STOPPED, tick_q=0, mode_q=0, index=0, bounce_dn=0.

Step detection:
- tick_q <= tick_in every cycle.
- step = tick_in & ~tick_q (rising edge).
- leds update on the same clock edge at which step is true, i.e. visible 1 cycle after tick_in first reads high.

States:
- STOPPED: leds=0.
  - run=1 → RUNNING; leds load the start pattern of the current mode; index=0; bounce_dn=0.
  - A step in that cycle is ignored.
- RUNNING:
  - run=0 → STOPPED; leds=0 next cycle; wrap=0.
  - mode != mode_q → reload start pattern, index=0, bounce_dn=0; no wrap; a coincident step is ignored.
  - Otherwise, step & ~hold → advance the pattern as below.
  - hold=1 → leds frozen; steps are dropped, not queued.
- mode_q <= mode every cycle.

Patterns (start value / advance / wrap condition):
- Mode 0 walk:
  - Start 1 (LSB).
  - dir=0 rotates left, dir=1 rotates right; index counts 0..LED_COUNT-1.
  - wrap when index goes LED_COUNT-1 → 0.
- Mode 1 binary:
  - Start 0.
  - dir=0: +1 modulo 2^LED_COUNT. dir=1: -1 modulo 2^LED_COUNT.
  - wrap on all-ones → 0 (up) or 0 → all-ones (down).
- Mode 2 bounce:
  - Start 1.
  - One-hot moves toward the MSB until bit LED_COUNT-1, sets bounce_dn, then moves toward bit 0 and clears bounce_dn there.
  - Period is 2*(LED_COUNT-1) steps; the end bits are not repeated.
  - wrap on arrival at bit 0. dir is ignored.
- Mode 3 blink:
  - Start 0.
  - Toggles between 0 and all-ones.
  - wrap on each return to 0. dir is ignored.

Direction changes:
- A dir change mid-pattern takes effect on the next step with no reload.

wrap timing:
- wrap is registered and asserted in the same cycle that leds show the wrapped value.
- wrap is 0 in every other cycle, including reloads.

Optional Feature:
- Macro: LED_SEQ_BOTH_EDGES_EN.
- Defined: step = tick_in ^ tick_q, so both edges of tick_in advance the pattern. This gives one step per divider interval rather than per full output period.
- Undefined: rising-edge-only stepping as described above.
- All other behaviour is identical.

Test Plan:
All scenarios use LED_COUNT=5.
- Reset held 3 cycles with run=1 and tick_in toggling → leds=0, wrap=0 throughout; first cycle after release shows leds=00001 (mode 0).
- Mode 0, dir=0, run=1; 6 rising tick edges → leds 00010, 00100, 01000, 10000, 00001, 00010; wrap high exactly on the cycle leds=00001. Then dir=1 → next step gives 00001.
- Mode 1, dir=1 from start → first step gives leds=11111 with wrap=1; next step gives 11110 with wrap=0.
- Mode 2, 9 steps → 00010, 00100, 01000, 10000, 01000, 00100, 00010, 00001 (wrap=1), 00010.
- hold=1 across 3 tick rises → leds unchanged. Then switch mode 0→3 coincident with a tick edge → leds=00000, no wrap; next step gives 11111.
- run dropped mid-pattern → leds=0 next cycle. With LED_SEQ_BOTH_EDGES_EN defined, mode 1: 4 tick_in toggles → leds=00100.
